bus_controller: RTL and testbench

- Downstream of the CPU bus port; takes single CPU transactions (address, data, valid, instr, write-enable) and routes each to one of two slaves: RAM or IO.
- Provides address decode and a registered request/response handshake.
- Per-transaction timeout protects the CPU from hung slaves.
- Decode faults and timeouts complete the transaction with zero data and a one-cycle busError pulse, so the CPU never stalls forever.

---
 rtl/bus_controller.sv | 140 ++++++++++++++
 tb/tb_bus_controller.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_controller.sv
// Routes single CPU transactions to a RAM or IO slave with address decode,
// a registered handshake and a per-transaction timeout that ends in busError.
module bus_controller #(
  parameter logic [31:0] RAM_BASE       = 32'h0000_0000,
  parameter logic [31:0] RAM_MASK       = 32'hF000_0000,
  parameter logic [31:0] IO_BASE        = 32'hF000_0000,
  parameter logic [31:0] IO_MASK        = 32'hF000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpuAddress,
  input  logic [31:0] cpuDataIn,
  output logic [31:0] cpuDataOut,
  input  logic        cpuValid,
  input  logic        cpuInstr,
  input  logic        cpuWriteEnable,
  output logic        cpuReady,
  output logic        busError,
  output logic [31:0] ramAddress,
  output logic [31:0] ioAddress,
  output logic [31:0] ramDataOut,
  output logic [31:0] ioDataOut,
  input  logic [31:0] ramDataIn,
  input  logic [31:0] ioDataIn,
  output logic        ramValid,
  output logic        ioValid,
  output logic        ramWriteEnable,
  output logic        ioWriteEnable,
  input  logic        ramReady,
  input  logic        ioReady
);
  typedef enum logic [1:0] {IDLE, ACCESS, FAULT, DONE} state_t;

  localparam logic [16:0] TMO = 17'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic        we_q, we_d, sel_io_q, sel_io_d, err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ram_hit, io_hit, slv_ready;
  logic [31:0] slv_rdata;

  assign ram_hit   = (cpuAddress & RAM_MASK) == RAM_BASE;
  assign io_hit    = (cpuAddress & IO_MASK) == IO_BASE;
  assign slv_ready = sel_io_q ? ioReady : ramReady;
  assign slv_rdata = sel_io_q ? ioDataIn : ramDataIn;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    we_d     = we_q;
    sel_io_d = sel_io_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        err_d = 1'b0;
        if (cpuValid) begin
          addr_d  = cpuAddress;
          wdata_d = cpuDataIn;
          we_d    = cpuWriteEnable;
          // RAM wins when both regions match; IO rejects instruction fetches
          if (cpuInstr && cpuWriteEnable) begin
            state_d = FAULT;
          end else if (ram_hit) begin
            sel_io_d = 1'b0;
            state_d  = ACCESS;
          end else if (io_hit && !cpuInstr) begin
            sel_io_d = 1'b1;
            state_d  = ACCESS;
          end else begin
            state_d = FAULT;
          end
        end
      end
      ACCESS: begin
        // ready on the final allowed cycle is still a success
        if (slv_ready) begin
          rdata_d = we_q ? 32'h0 : slv_rdata;
          state_d = DONE;
        end else if ({1'b0, cnt_q} + 17'd1 >= TMO) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      FAULT: begin
        rdata_d = 32'h0;
        err_d   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      we_q     <= 1'b0;
      sel_io_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      we_q     <= we_d;
      sel_io_q <= sel_io_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ramValid       = (state_q == ACCESS) && !sel_io_q;
  assign ioValid        = (state_q == ACCESS) && sel_io_q;
  assign ramWriteEnable = ramValid && we_q;
  assign ioWriteEnable  = ioValid && we_q;
  assign ramAddress     = addr_q;
  assign ioAddress      = addr_q;
  assign ramDataOut     = wdata_q;
  assign ioDataOut      = wdata_q;
  assign cpuReady       = (state_q == DONE);
  assign busError       = cpuReady && err_q;
  assign cpuDataOut     = rdata_q;
endmodule

// File: tb/tb_bus_controller.sv
// Bench for bus_controller: vector table, randomized traffic against a
// transaction-level model, and hand sequences for reset and back-to-back.
module tb_bus_controller;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpuAddress, cpuDataIn, cpuDataOut;
  logic        cpuValid, cpuInstr, cpuWriteEnable, cpuReady, busError;
  logic [31:0] ramAddress, ioAddress, ramDataOut, ioDataOut, ramDataIn, ioDataIn;
  logic        ramValid, ioValid, ramWriteEnable, ioWriteEnable, ramReady, ioReady;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_controller #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .cpuAddress(cpuAddress), .cpuDataIn(cpuDataIn), .cpuDataOut(cpuDataOut),
    .cpuValid(cpuValid), .cpuInstr(cpuInstr), .cpuWriteEnable(cpuWriteEnable),
    .cpuReady(cpuReady), .busError(busError),
    .ramAddress(ramAddress), .ioAddress(ioAddress),
    .ramDataOut(ramDataOut), .ioDataOut(ioDataOut),
    .ramDataIn(ramDataIn), .ioDataIn(ioDataIn),
    .ramValid(ramValid), .ioValid(ioValid),
    .ramWriteEnable(ramWriteEnable), .ioWriteEnable(ioWriteEnable),
    .ramReady(ramReady), .ioReady(ioReady)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        instr;
    int          waitc;
    logic [31:0] rdata;
    int          e_lat;
    logic [31:0] e_dat;
    logic        e_err;
    int          e_vr;
    int          e_vi;
  } vec_t;

  typedef struct {
    int          lat;
    logic [31:0] dat;
    logic        err;
    int          vr;
    int          vi;
    logic [31:0] oa;
    logic [31:0] ow;
    logic        owe;
    logic        rdy_after;
  } res_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transaction-level view: decode, fault, timeout and latency from the rules.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    bit ram   = (v.addr & 32'hF000_0000) == 32'h0000_0000;
    bit io    = (v.addr & 32'hF000_0000) == 32'hF000_0000;
    bit fault = (v.instr && v.we) || !(ram || (io && !v.instr));
    bit to    = !fault && (v.waitc >= TMO);
    int vcyc  = to ? TMO : v.waitc + 1;
    r.e_lat = fault ? 2 : (to ? TMO + 1 : v.waitc + 2);
    r.e_dat = (fault || to || v.we) ? 32'h0 : v.rdata;
    r.e_err = fault || to;
    r.e_vr  = (!fault && ram) ? vcyc : 0;
    r.e_vi  = (!fault && !ram) ? vcyc : 0;
    return r;
  endfunction

  // Issues one request for a single cycle and plays the selected slave,
  // answering after v.waitc wait cycles.
  task automatic run_txn(input vec_t v, output res_t r);
    r = '{lat: -1, dat: 32'h0, err: 1'b0, vr: 0, vi: 0, oa: 32'h0, ow: 32'h0, owe: 1'b0, rdy_after: 1'b0};
    @(posedge clk); #1;
    cpuValid = 1'b1; cpuAddress = v.addr; cpuDataIn = v.wdata;
    cpuWriteEnable = v.we; cpuInstr = v.instr;
    ramDataIn = v.rdata; ioDataIn = v.rdata;
    @(posedge clk); #1;
    cpuValid = 1'b0; cpuAddress = $urandom; cpuDataIn = $urandom;
    for (int c = 1; c <= 40; c++) begin
      ramReady = 1'b0; ioReady = 1'b0;
      if (ramValid || ioValid) begin
        if (r.vr + r.vi == 0) begin
          r.oa  = ramValid ? ramAddress : ioAddress;
          r.ow  = ramValid ? ramDataOut : ioDataOut;
          r.owe = ramValid ? ramWriteEnable : ioWriteEnable;
        end
        if (r.vr + r.vi == v.waitc) begin
          ramReady = ramValid; ioReady = ioValid;
        end
        if (ramValid) r.vr++;
        if (ioValid) r.vi++;
      end
      @(negedge clk);
      if (cpuReady) begin
        r.lat = c; r.dat = cpuDataOut; r.err = busError;
        break;
      end
      @(posedge clk); #1;
    end
    ramReady = 1'b0; ioReady = 1'b0;
    @(negedge clk);
    r.rdy_after = cpuReady | busError;
  endtask

  task automatic check_txn(input string tag, input vec_t v, input res_t r);
    chk({tag, ".latency"}, 32'(r.lat), 32'(v.e_lat));
    chk({tag, ".data"}, r.dat, v.e_dat);
    chk({tag, ".busError"}, 32'(r.err), 32'(v.e_err));
    chk({tag, ".ramValidCycles"}, 32'(r.vr), 32'(v.e_vr));
    chk({tag, ".ioValidCycles"}, 32'(r.vi), 32'(v.e_vi));
    chk({tag, ".readyOneCycle"}, 32'(r.rdy_after), 32'h0);
    if (v.e_vr + v.e_vi > 0) begin
      chk({tag, ".slaveAddr"}, r.oa, v.addr);
      chk({tag, ".slaveData"}, r.ow, v.wdata);
      chk({tag, ".slaveWe"}, 32'(r.owe), 32'(v.we));
    end
  endtask

  vec_t tbl[10];
  vec_t v;
  res_t r;
  logic [31:0] bb_d[2];
  int pulses, rises, overlap;
  logic prev;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cpuValid = 1'b0; cpuInstr = 1'b0; cpuWriteEnable = 1'b0;
    cpuAddress = 32'h0; cpuDataIn = 32'h0; ramDataIn = 32'h0; ioDataIn = 32'h0;
    ramReady = 1'b0; ioReady = 1'b0;

    //          addr          wdata         we    instr wait rdata         lat dat           err  vr vi
    tbl[0] = '{32'h0000_0010, 32'h0,        1'b0, 1'b0, 0,  32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, 1'b0, 1, 0};
    tbl[1] = '{32'hF000_0004, 32'h1234_5678, 1'b1, 1'b0, 3,  32'hAAAA_AAAA, 5, 32'h0,         1'b0, 0, 4};
    tbl[2] = '{32'hF000_0000, 32'h0,        1'b0, 1'b1, 0,  32'h5555_5555, 2, 32'h0,         1'b1, 0, 0};
    tbl[3] = '{32'h5000_0000, 32'h0,        1'b0, 1'b0, 0,  32'h5555_5555, 2, 32'h0,         1'b1, 0, 0};
    tbl[4] = '{32'h0000_0020, 32'h0,        1'b0, 1'b0, 50, 32'h7777_7777, 5, 32'h0,         1'b1, 4, 0};
    tbl[5] = '{32'h0000_0030, 32'h0,        1'b0, 1'b0, 1,  32'hCAFE_F00D, 3, 32'hCAFE_F00D, 1'b0, 2, 0};
    tbl[6] = '{32'h0000_0040, 32'h9,        1'b1, 1'b1, 0,  32'h1,         2, 32'h0,         1'b1, 0, 0};
    tbl[7] = '{32'h0000_0080, 32'h0,        1'b0, 1'b1, 0,  32'h1111_2222, 2, 32'h1111_2222, 1'b0, 1, 0};
    tbl[8] = '{32'hF000_0100, 32'h0,        1'b0, 1'b0, 0,  32'h8765_4321, 2, 32'h8765_4321, 1'b0, 0, 1};
    tbl[9] = '{32'h0FFF_FFFC, 32'hABCD,     1'b1, 1'b0, 2,  32'h1,         4, 32'h0,         1'b0, 3, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.cpuReady", 32'(cpuReady), 32'h0);
    chk("rst.busError", 32'(busError), 32'h0);
    chk("rst.valids", 32'({ramValid, ioValid, ramWriteEnable, ioWriteEnable}), 32'h0);
    chk("rst.cpuDataOut", cpuDataOut, 32'h0);
    chk("rst.slaveOuts", ramAddress | ioAddress | ramDataOut | ioDataOut, 32'h0);
    @(posedge clk); #1 reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i], r);
      check_txn($sformatf("vec%0d", i), tbl[i], r);
    end

    for (int i = 0; i < 60; i++) begin
      v.addr = $urandom & 32'h0FFF_FFFC;
      case ($urandom_range(0, 2))
        0: v.addr[31:28] = 4'h0;
        1: v.addr[31:28] = 4'hF;
        default: v.addr[31:28] = 4'($urandom_range(1, 14));
      endcase
      v.wdata = $urandom; v.rdata = $urandom;
      v.we = 1'($urandom_range(0, 1)); v.instr = ($urandom_range(0, 3) == 0);
      v.waitc = $urandom_range(0, 6);
      v = model(v);
      run_txn(v, r);
      check_txn($sformatf("rnd%0d", i), v, r);
    end

    // reset while a RAM access is stalled
    @(posedge clk); #1;
    cpuValid = 1'b1; cpuAddress = 32'h0000_0200; cpuWriteEnable = 1'b1;
    cpuInstr = 1'b0; cpuDataIn = 32'h1357_9BDF;
    @(posedge clk); #1 cpuValid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rstmid.ramValidBefore", 32'(ramValid), 32'h1);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rstmid.ramValid", 32'(ramValid), 32'h0);
    chk("rstmid.ramWe", 32'(ramWriteEnable), 32'h0);
    chk("rstmid.cpuReady", 32'(cpuReady), 32'h0);
    chk("rstmid.slaveOuts", ramAddress | ramDataOut, 32'h0);
    chk("rstmid.cpuDataOut", cpuDataOut, 32'h0);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (cpuReady || ramValid) pulses++;
    end
    chk("rstmid.noLateActivity", 32'(pulses), 32'h0);

    // cpuValid held high over two back-to-back RAM reads
    @(posedge clk); #1;
    cpuValid = 1'b1; cpuAddress = 32'h0000_0100; cpuWriteEnable = 1'b0; cpuInstr = 1'b0;
    pulses = 0; rises = 0; overlap = 0; prev = 1'b0;
    bb_d[0] = 32'h0; bb_d[1] = 32'h0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (pulses == 1) cpuAddress = 32'h0000_0104;
      if (pulses >= 2) cpuValid = 1'b0;
      ramReady = ramValid; ramDataIn = ramAddress ^ 32'h5A5A_0000;
      @(negedge clk);
      if (ramValid && !prev) rises++;
      prev = ramValid;
      if (cpuReady) begin
        if (ramValid) overlap++;
        if (pulses < 2) bb_d[pulses] = cpuDataOut;
        pulses++;
      end
    end
    ramReady = 1'b0;
    chk("b2b.pulses", 32'(pulses), 32'h2);
    chk("b2b.valid_phases", 32'(rises), 32'h2);
    chk("b2b.overlap", 32'(overlap), 32'h0);
    chk("b2b.data0", bb_d[0], 32'h5A5A_0100);
    chk("b2b.data1", bb_d[1], 32'h5A5A_0104);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
